// File: rtl/ram_pkg.sv
// Shared definitions for the 8-bit-write / 16-bit-read block RAM slice.
// Holds the default read-port address width, data widths, pointer types and a
// modulo pointer distance helper used by both the writer and reader sides.
package ram_pkg;

  localparam int unsigned ADDR_W = 9;   // read-port word address width (512 words)
  localparam int unsigned DATA_W = 16;  // read-port word width
  localparam int unsigned BYTE_W = 8;   // write-port byte width

  // Byte pointer: ADDR_W+1 byte-address bits plus a wrap bit.
  typedef logic [ADDR_W+1:0] byte_ptr_t;
  // Word pointer: ADDR_W word-address bits plus a wrap bit.
  typedef logic [ADDR_W:0]   word_ptr_t;

  // Distance a - b modulo 2^(ADDR_W+1); the wrap bit separates full from empty.
  function automatic word_ptr_t ptr_diff(input word_ptr_t a, input word_ptr_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/sync_skid_fifo.sv
// Small synchronous first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   clr_i    synchronous flush (wins over push and pop)
//   push_i   write wdata_i; caller guarantees room
//   wdata_i  write data
//   pop_i    consume the head entry; ignored when empty
//   rdata_o  head entry, forced to zero while empty
//   valid_o  FIFO not empty
//   count_o  number of stored entries
module sync_skid_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 16,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i & (count_q != '0);
  assign valid_o = (count_q != '0);
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= ptr_inc(wptr_q);
      if (do_pop) rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + CntW'(push_i) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: the output is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

`ifndef SYNTHESIS
  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (push_i && !do_pop && !clr_i) |-> (count_q < CntW'(Depth)))
    else $error("sync_skid_fifo: push into full FIFO");
`endif

endmodule

// File: rtl/ram_w16_rd_ctrl.sv
// Read-side controller for the 1024x8 write / 512x16 read block RAM.
// Follows the writer's byte pointer, issues word reads only for fully written
// words, absorbs the RAM read latency and presents a valid/ready stream.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous flush, pulsed with the writer's clear
//   wr_ptr            writer byte pointer (address bits + wrap bit)
//   rd_ptr            word read pointer (address bits + wrap bit) back to writer
//   adb, ceb, oce     RAM read-port address, clock enable, output-register enable
//   ram_dout          RAM read data, [7:0] even byte, [15:8] odd byte
//   m_data, m_valid,
//   m_ready           output word stream
//   level             committed words not yet read
module ram_w16_rd_ctrl #(
  parameter int unsigned ADDR_W = ram_pkg::ADDR_W,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned FIFO_D = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [ADDR_W+1:0]         wr_ptr,
  output logic [ADDR_W:0]           rd_ptr,
  output logic [ADDR_W-1:0]         adb,
  output logic                      ceb,
  output logic                      oce,
  input  logic [ram_pkg::DATA_W-1:0] ram_dout,
  output logic [ram_pkg::DATA_W-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [ADDR_W:0]           level
);

  localparam int unsigned CntW = $clog2(FIFO_D + 1);

  logic [ADDR_W:0]   wr_wptr, level_now;
  logic [ADDR_W:0]   rd_ptr_d, rd_ptr_q;
  logic [ADDR_W:0]   level_d, level_q;
  logic [RD_LAT-1:0] tag_d, tag_q;
  logic [CntW-1:0]   fifo_count;
  logic              issue, pop, push;
  int                occ;
  logic              unused_wr_lsb;

  // Dropping the byte LSB hides a half-written word from the reader.
  assign wr_wptr       = wr_ptr[ADDR_W+1:1];
  assign unused_wr_lsb = wr_ptr[0];
  assign level_now     = wr_wptr - rd_ptr_q;

  assign pop  = m_valid & m_ready;
  assign push = tag_q[RD_LAT-1] & ~clr;

  // Reads in flight plus FIFO contents must never exceed the FIFO depth, so
  // every returning word has a slot even under full backpressure.
  always_comb begin
    occ   = $countones(tag_q) + int'(fifo_count) - int'(pop);
    issue = (level_now != '0) && !clr && (occ < int'(FIFO_D));
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    tag_d    = tag_q << 1;
    tag_d[0] = issue;
    level_d  = level_now;
    if (clr) begin
      rd_ptr_d = '0;
      tag_d    = '0;
      level_d  = '0;
    end else if (issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      tag_q    <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      tag_q    <= tag_d;
      level_q  <= level_d;
    end
  end

  assign ceb    = issue;
  assign adb    = rd_ptr_q[ADDR_W-1:0];
  assign rd_ptr = rd_ptr_q;
  assign level  = level_q;

  // In output-register mode the register loads while a tag sits in stage 1.
  if (RD_LAT == 1) begin : g_oce_bypass
    assign oce = 1'b1;
  end else begin : g_oce_pipe
    assign oce = tag_q[0];
  end

  sync_skid_fifo #(
    .Depth (FIFO_D),
    .Width (ram_pkg::DATA_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (clr),
    .push_i  (push),
    .wdata_i (ram_dout),
    .pop_i   (pop),
    .rdata_o (m_data),
    .valid_o (m_valid),
    .count_o (fifo_count)
  );

endmodule

// File: doc/ram_w16_rd_ctrl.md
Name: ram_w16_rd_ctrl

Overview:
Downstream read-side controller for the 8-bit-write / 16-bit-read block RAM (1024 x 8 write port, 512 x 16 read port, same clock on both ports). It tracks the upstream byte writer's pointer, issues word reads only when both bytes of a word are committed, and absorbs the fixed RAM read latency. It presents the words as a valid/ready stream with full backpressure and returns its read pointer so the writer can detect full.

Parameters:
ADDR_W, 9, RAM read-port word address width (512 words)
RD_LAT, 1, RAM read latency in cycles; 1 = bypass mode, 2 = output-register mode (oce used as pipeline enable)
FIFO_D, 2, output skid-FIFO depth; must be >= RD_LAT+1

Ports:
clk  in  1  single clock, drives both RAM ports
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush; pulsed together with the writer's clear
wr_ptr  in  ADDR_W+2  writer byte pointer: ADDR_W+1 address bits plus 1 wrap bit
rd_ptr  out  ADDR_W+1  word read pointer: ADDR_W address bits plus 1 wrap bit, returned to writer
adb  out  ADDR_W  RAM read address
ceb  out  1  RAM read-port clock enable (1 = read issued this cycle)
oce  out  1  RAM output-register enable
ram_dout  in  16  RAM read data; [7:0] = even byte, [15:8] = odd byte
m_data  out  16  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
level  out  ADDR_W+1  committed words not yet read (diagnostic)

Behaviour:
- Reset (rst_n low, asynchronous): rd_ptr=0, ceb=0, m_valid=0, m_data=0, level=0, in-flight count=0, FIFO empty. oce=1 when RD_LAT=1.
- Word pointer: wr_wptr = wr_ptr[ADDR_W+1:1]. The LSB is dropped, so a half-written word (odd byte count) is never available.
- level = (wr_wptr - rd_ptr) mod 2^(ADDR_W+1), registered each cycle. Range 0..2^ADDR_W. Wrap bit distinguishes full from empty.
- Issue rule, per cycle: ceb=1 and adb=rd_ptr[ADDR_W-1:0] iff level_now>0, clr=0, and (inflight + fifo_count - pop) < FIFO_D, where pop = m_valid & m_ready.
  - level_now is computed combinationally from the current wr_ptr/rd_ptr, not the registered level.
  - On issue, rd_ptr increments on the same edge; the address wraps from 511 to 0 and the wrap bit toggles.
- Latency: RAM data is sampled RD_LAT cycles after the issue edge via a RD_LAT-deep shift of valid tags, and pushed into the FIFO. First-word latency from wr_ptr reaching an even count to m_valid=1: RD_LAT+1 cycles.
- oce: constant 1 for RD_LAT=1. For RD_LAT=2, oce=1 whenever any tag is in stage 1.
- FIFO behaviour:
  - First-word-fall-through: m_valid = (fifo_count>0).
  - Simultaneous push and pop keeps the count unchanged.
  - Overflow cannot occur by construction; an assertion checks it.
- Throughput: with m_ready held high and level>0, one word per cycle sustained.
- Backpressure: with m_ready low, at most FIFO_D reads are outstanding. After that ceb=0 until a pop. m_data and m_valid hold stable while m_ready is low.
- clr: on the next edge, rd_ptr=0, FIFO emptied, in-flight tags discarded (returning RAM data is ignored), m_valid=0. No issue occurs in the clr cycle. clr has priority over issue and pop.
- Reset mid-burst: all state clears immediately; discarded in-flight data never appears on m_data.
- No read is ever issued when level_now=0, including the cycle in which wr_ptr wraps.

Decomposition:
- Shared package ram_pkg: ADDR_W, DATA_W=16, BYTE_W=8, pointer typedefs (byte pointer ADDR_W+2 bits, word pointer ADDR_W+1 bits), and a function ptr_diff(a,b) for mod-2^N distance.
- One natural sub-module: sync_skid_fifo (parameterised depth/width, FWFT, count output). It is reusable on the writer side as well.

Test Plan:
1. Reset then wr_ptr=0 -> ceb stays 0, m_valid=0, rd_ptr=0, level=0 for 20 cycles.
2. Writer writes bytes 0x11,0x22 (wr_ptr 0->1->2) -> no read at wr_ptr=1; at wr_ptr=2 ceb pulses with adb=0, and m_data=0x2211 with m_valid RD_LAT+1 cycles later; rd_ptr=1.
3. Preload 8 words, m_ready=1 -> 8 consecutive ceb cycles on adb 0..7 and 8 consecutive valid words in order; level falls 8->0.
4. Preload 8 words, m_ready=0 for 10 cycles then 1 -> exactly FIFO_D reads issued while stalled, m_data held stable, then the remaining 6 words arrive with no loss or duplication.
5. Wrap: rd_ptr=510 with wrap=0 and writer at word 514 -> reads on adb 510, 511, 0, 1; rd_ptr ends at 2 with wrap bit=1; data order preserved.
6. Full/clr: writer fills 512 words (level=512), then clr asserted with 1 read in flight -> next cycle m_valid=0, rd_ptr=0, and no stale word is emitted afterwards.
